// File: rtl/util_sequences_sync_ctrl_if.sv
// Stream bundle around the sync controller: the upstream stream (s_axis_*) going in and
// the frame-aligned stream (m_axis_*) coming out. The controller takes the slave view;
// the master view belongs to whatever drives the input and consumes the output.
interface util_sequences_sync_ctrl_if #(
    parameter int unsigned TDATA_WIDTH = 8
) ();

    logic                   s_axis_tvalid;
    logic [TDATA_WIDTH-1:0] s_axis_tdata;
    logic                   s_axis_tready;

    logic                   m_axis_tvalid;
    logic [TDATA_WIDTH-1:0] m_axis_tdata;
    logic                   m_axis_tuser;
    logic                   m_axis_tlast;
    logic                   m_axis_tready;

    modport master (
        output s_axis_tvalid,
        output s_axis_tdata,
        input  s_axis_tready,
        input  m_axis_tvalid,
        input  m_axis_tdata,
        input  m_axis_tuser,
        input  m_axis_tlast,
        output m_axis_tready
    );

    modport slave (
        input  s_axis_tvalid,
        input  s_axis_tdata,
        output s_axis_tready,
        output m_axis_tvalid,
        output m_axis_tdata,
        output m_axis_tuser,
        output m_axis_tlast,
        input  m_axis_tready
    );

endinterface

// File: rtl/util_sequences_sync_ctrl.sv
// Frame-alignment controller: hunts for a fixed sync header, confirms it over LOCK_CNT
// frames, then forwards whole aligned frames with tuser on the first beat and tlast on
// the last. Beats are dropped (not stalled) whenever forwarding is off.
module util_sequences_sync_ctrl #(
    parameter int unsigned TDATA_WIDTH   = 8,
    parameter int unsigned SEQUENCES_LEN = 4,
    parameter logic [SEQUENCES_LEN*TDATA_WIDTH-1:0] SEQUENCES_PACK = '0,
    parameter int unsigned FRAME_LEN     = 256,
    parameter int unsigned LOCK_CNT      = 3,
    parameter int unsigned UNLOCK_CNT    = 2,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    util_sequences_sync_ctrl_if.slave axis,
    output logic                      locked,
    output logic [1:0]                state,
    output logic [CNT_WIDTH-1:0]      err_cnt,
    output logic [CNT_WIDTH-1:0]      frame_cnt
);

    localparam int unsigned BcntW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned HitW    = $clog2(LOCK_CNT + 1);
    localparam int unsigned MissW   = $clog2(UNLOCK_CNT + 1);
    // Keep at least one history slot so the array is never zero-sized.
    localparam int unsigned HistLen = (SEQUENCES_LEN > 1) ? SEQUENCES_LEN - 1 : 1;

    localparam logic [BcntW-1:0] CheckBeat    = BcntW'(SEQUENCES_LEN - 1);
    localparam logic [BcntW-1:0] HeaderEnd    = BcntW'(SEQUENCES_LEN);
    localparam logic [BcntW-1:0] LastBeat     = BcntW'(FRAME_LEN - 1);
    localparam logic [HitW-1:0]  LockHits     = HitW'(LOCK_CNT);
    localparam logic [MissW-1:0] UnlockMisses = MissW'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        StHunt  = 2'd0,
        StCheck = 2'd1,
        StLock  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [BcntW-1:0]       bcnt_q, bcnt_d;
    logic [HitW-1:0]        hit_cnt_q, hit_cnt_d;
    logic [MissW-1:0]       miss_cnt_q, miss_cnt_d;
    logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic                   aligned_q, aligned_d;
    logic [TDATA_WIDTH-1:0] hist_q [HistLen];
    logic [TDATA_WIDTH-1:0] hist_d [HistLen];

    logic fwd;
    logic s_ready;
    logic m_valid;
    logic m_last;
    logic acc;
    logic hit;
    logic check_beat;
    logic last_beat;
    logic frame_done;

    assign fwd        = (state_q == StLock) & aligned_q;
    assign s_ready    = fwd ? axis.m_axis_tready : 1'b1;
    assign acc        = axis.s_axis_tvalid & s_ready;
    assign check_beat = (bcnt_q == CheckBeat);
    assign last_beat  = (bcnt_q == LastBeat);
    assign m_valid    = axis.s_axis_tvalid & fwd;
    assign m_last     = fwd & last_beat;
    assign frame_done = m_valid & axis.m_axis_tready & m_last;

    assign axis.s_axis_tready = s_ready;
    assign axis.m_axis_tvalid = m_valid;
    assign axis.m_axis_tdata  = axis.s_axis_tdata;
    assign axis.m_axis_tuser  = fwd & (bcnt_q == '0);
    assign axis.m_axis_tlast  = m_last;

    assign locked    = (state_q == StLock);
    assign state     = state_q;
    assign err_cnt   = err_cnt_q;
    assign frame_cnt = frame_cnt_q;

    // Header match: history (oldest first) followed by the current beat.
    always_comb begin
        hit = (axis.s_axis_tdata ==
               SEQUENCES_PACK[(SEQUENCES_LEN-1)*TDATA_WIDTH +: TDATA_WIDTH]);
        for (int i = 0; i < int'(SEQUENCES_LEN) - 1; i++) begin
            if (hist_q[i] != SEQUENCES_PACK[i*TDATA_WIDTH +: TDATA_WIDTH]) begin
                hit = 1'b0;
            end
        end
    end

    // Next-state: hunt/check/lock sequencing, beat counter, history and status counters.
    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_cnt_d   = err_cnt_q;
        frame_cnt_d = frame_cnt_q;
        aligned_d   = aligned_q;
        hist_d      = hist_q;

        if (acc) begin
            bcnt_d = last_beat ? '0 : bcnt_q + BcntW'(1);
            for (int i = 0; i < int'(HistLen) - 1; i++) begin
                hist_d[i] = hist_q[i+1];
            end
            hist_d[HistLen-1] = axis.s_axis_tdata;

            unique case (state_q)
                StHunt: begin
                    if (hit) begin
                        // Re-phase the counter so the next beat is the first payload beat.
                        bcnt_d     = HeaderEnd;
                        hit_cnt_d  = HitW'(1);
                        miss_cnt_d = '0;
                        state_d    = (LOCK_CNT == 1) ? StLock : StCheck;
                    end
                end
                StCheck: begin
                    if (check_beat) begin
                        if (hit) begin
                            hit_cnt_d = hit_cnt_q + HitW'(1);
                            if (hit_cnt_q + HitW'(1) == LockHits) begin
                                state_d    = StLock;
                                miss_cnt_d = '0;
                            end
                        end else begin
                            state_d   = StHunt;
                            hit_cnt_d = '0;
                        end
                    end
                end
                StLock: begin
                    // Forwarding starts on the next frame boundary, never mid-frame.
                    if (last_beat) begin
                        aligned_d = 1'b1;
                    end
                    if (check_beat) begin
                        if (hit) begin
                            miss_cnt_d = '0;
                        end else begin
                            if (err_cnt_q != '1) begin
                                err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
                            end
                            miss_cnt_d = miss_cnt_q + MissW'(1);
                            if (miss_cnt_q + MissW'(1) == UnlockMisses) begin
                                state_d   = StHunt;
                                aligned_d = 1'b0;
                                hit_cnt_d = '0;
                            end
                        end
                    end
                end
                default: begin
                    state_d   = StHunt;
                    aligned_d = 1'b0;
                end
            endcase
        end

        if (frame_done && (frame_cnt_q != '1)) begin
            frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
        end

        if (!en) begin
            state_d     = StHunt;
            bcnt_d      = '0;
            hit_cnt_d   = '0;
            miss_cnt_d  = '0;
            err_cnt_d   = '0;
            frame_cnt_d = '0;
            aligned_d   = 1'b0;
            hist_d      = '{default: '0};
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StHunt;
            bcnt_q      <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            err_cnt_q   <= '0;
            frame_cnt_q <= '0;
            aligned_q   <= 1'b0;
            hist_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_cnt_q   <= err_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            aligned_q   <= aligned_d;
            hist_q      <= hist_d;
        end
    end

endmodule

// File: tb/tb_util_sequences_sync_ctrl.sv
// Bench for util_sequences_sync_ctrl: randomized beats/gaps/backpressure against a
// behavioural frame-alignment model, plus literal checks on the scripted scenarios.
module tb_util_sequences_sync_ctrl;

    localparam int W      = 8;
    localparam int L      = 4;
    localparam int F      = 16;
    localparam int LOCKN  = 3;
    localparam int UNLOCK = 2;
    localparam int CW     = 16;
    localparam int MAXC   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic          locked;
    logic [1:0]    state;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] frame_cnt;

    util_sequences_sync_ctrl_if #(.TDATA_WIDTH(W)) axis_if ();

    util_sequences_sync_ctrl #(
        .TDATA_WIDTH   (W),
        .SEQUENCES_LEN (L),
        .SEQUENCES_PACK({8'hDD, 8'hCC, 8'hBB, 8'hAA}),
        .FRAME_LEN     (F),
        .LOCK_CNT      (LOCKN),
        .UNLOCK_CNT    (UNLOCK),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .axis     (axis_if),
        .locked   (locked),
        .state    (state),
        .err_cnt  (err_cnt),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: frame phase, hit/miss tallies and the last L-1 accepted bytes.
    int         m_state, m_bcnt, m_hits, m_misses, m_err, m_frames;
    bit         m_aligned;
    logic [7:0] m_hist[$];

    // Per-accepted-beat observations of the DUT, for the scripted literal checks.
    logic       obs_valid[$];
    logic       obs_user[$];
    logic       obs_last[$];
    logic [1:0] obs_state[$];
    logic [7:0] obs_data[$];
    logic       last_sready;

    function automatic logic [7:0] hdr(input int i);
        case (i)
            0:       return 8'hAA;
            1:       return 8'hBB;
            2:       return 8'hCC;
            default: return 8'hDD;
        endcase
    endfunction

    function automatic logic [7:0] payload();
        return 8'($urandom_range(8'h10, 8'h7F));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_bcnt    = 0;
        m_hits    = 0;
        m_misses  = 0;
        m_err     = 0;
        m_frames  = 0;
        m_aligned = 0;
        m_hist    = {};
        for (int i = 0; i < L - 1; i++) m_hist.push_back(8'h00);
    endtask

    task automatic model_update(input logic v, input logic [7:0] d, input logic mr,
                                input logic e);
        bit fwd, acc, hit, chkb;
        int nb;
        if (!e) begin
            model_reset();
            return;
        end
        fwd = (m_state == 2) && m_aligned;
        acc = v && (fwd ? mr : 1'b1);
        if (fwd && v && mr && (m_bcnt == F - 1) && (m_frames < MAXC)) m_frames++;
        if (!acc) return;
        hit = (d == hdr(L - 1));
        for (int i = 0; i < L - 1; i++) if (m_hist[i] != hdr(i)) hit = 0;
        chkb = (m_bcnt == L - 1);
        nb   = (m_bcnt + 1) % F;
        case (m_state)
            0: if (hit) begin
                nb       = L;
                m_hits   = 1;
                m_misses = 0;
                m_state  = (LOCKN == 1) ? 2 : 1;
            end
            1: if (chkb) begin
                if (hit) begin
                    m_hits++;
                    if (m_hits == LOCKN) begin
                        m_state  = 2;
                        m_misses = 0;
                    end
                end else begin
                    m_state = 0;
                    m_hits  = 0;
                end
            end
            default: begin
                if (m_bcnt == F - 1) m_aligned = 1;
                if (chkb) begin
                    if (hit) m_misses = 0;
                    else begin
                        if (m_err < MAXC) m_err++;
                        m_misses++;
                        if (m_misses == UNLOCK) begin
                            m_state   = 0;
                            m_aligned = 0;
                            m_hits    = 0;
                        end
                    end
                end
            end
        endcase
        m_bcnt = nb;
        m_hist.push_back(d);
        void'(m_hist.pop_front());
    endtask

    // One clock: drive at the falling edge, compare every output, advance model at the rise.
    task automatic cycle(input logic v, input logic [7:0] d, input logic mr, input logic e,
                         output bit accepted);
        bit e_fwd, e_sready, e_acc, e_mvalid;
        axis_if.s_axis_tvalid = v;
        axis_if.s_axis_tdata  = d;
        axis_if.m_axis_tready = mr;
        en                    = e;
        #1;
        e_fwd    = (m_state == 2) && m_aligned;
        e_sready = e_fwd ? mr : 1'b1;
        e_acc    = v && e_sready;
        e_mvalid = v && e_fwd;
        chk("s_axis_tready", 32'(axis_if.s_axis_tready), 32'(e_sready));
        chk("m_axis_tvalid", 32'(axis_if.m_axis_tvalid), 32'(e_mvalid));
        if (e_mvalid) chk("m_axis_tdata", 32'(axis_if.m_axis_tdata), 32'(d));
        chk("m_axis_tuser", 32'(axis_if.m_axis_tuser), 32'(e_fwd && (m_bcnt == 0)));
        chk("m_axis_tlast", 32'(axis_if.m_axis_tlast), 32'(e_fwd && (m_bcnt == F - 1)));
        chk("locked", 32'(locked), 32'(m_state == 2));
        chk("state", 32'(state), m_state);
        chk("err_cnt", 32'(err_cnt), m_err);
        chk("frame_cnt", 32'(frame_cnt), m_frames);
        last_sready = axis_if.s_axis_tready;
        accepted    = e_acc;
        if (e_acc) begin
            obs_valid.push_back(axis_if.m_axis_tvalid);
            obs_user.push_back(axis_if.m_axis_tuser);
            obs_last.push_back(axis_if.m_axis_tlast);
            obs_state.push_back(state);
            obs_data.push_back(axis_if.m_axis_tdata);
        end
        @(posedge clk);
        model_update(v, d, mr, e);
        @(negedge clk);
    endtask

    // Offer one beat with random idle gaps and backpressure until it is accepted.
    task automatic beat(input logic [7:0] d);
        bit   a;
        logic v, mr;
        a = 0;
        for (int k = 0; k < 6 && !a; k++) begin
            v  = (k >= 2) || ($urandom_range(0, 3) != 0);
            mr = (k >= 2) || ($urandom_range(0, 4) != 0);
            cycle(v, d, mr, 1'b1, a);
        end
        if (!a) chk("beat_accepted", 32'(a), 32'd1);
    endtask

    task automatic stall5(input logic [7:0] d);
        bit a;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, d, 1'b0, 1'b1, a);
            chk("stall_sready", 32'(last_sready), 32'd0);
        end
    endtask

    // kind 0 = good header, 1 = third header byte corrupted to 00.
    task automatic send_frame(input int kind, input int pad, input int stall_at);
        logic [7:0] d;
        obs_valid = {};
        obs_user  = {};
        obs_last  = {};
        obs_state = {};
        obs_data  = {};
        for (int p = 0; p < pad; p++) beat(payload());
        for (int i = 0; i < F; i++) begin
            d = (i < L) ? hdr(i) : payload();
            if (kind == 1 && i == 2) d = 8'h00;
            if (i == stall_at) stall5(d);
            beat(d);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit a;
        rstn                  = 1'b0;
        en                    = 1'b1;
        axis_if.s_axis_tvalid = 1'b0;
        axis_if.s_axis_tdata  = '0;
        axis_if.m_axis_tready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < 5; i++) beat(payload());
        send_frame(0, 0, -1);
        chk("check_after_hdr1", 32'(state), 32'd1);
        send_frame(0, 0, -1);
        chk("check_after_hdr2", 32'(state), 32'd1);
        send_frame(0, 0, -1);
        chk("lock_after_hdr3", 32'(state), 32'd2);
        chk("lock_frame_not_fwd", 32'(obs_valid[15]), 32'd0);
        send_frame(0, 0, -1);
        chk("f4_first_valid", 32'(obs_valid[0]), 32'd1);
        chk("f4_first_tuser", 32'(obs_user[0]), 32'd1);
        chk("f4_first_data", 32'(obs_data[0]), 32'hAA);
        chk("f4_tlast_16th", 32'(obs_last[15]), 32'd1);
        chk("f4_frame_cnt", 32'(frame_cnt), 32'd1);

        // Single corrupted header: counted, lock held, next frame forwarded.
        send_frame(1, 0, -1);
        chk("miss1_err", 32'(err_cnt), 32'd1);
        chk("miss1_state", 32'(state), 32'd2);
        send_frame(0, 0, -1);
        chk("after_miss1_frames", 32'(frame_cnt), 32'd3);
        chk("after_miss1_tuser", 32'(obs_user[0]), 32'd1);

        // Two consecutive misses: second one drops lock mid-frame, no tlast.
        send_frame(1, 0, -1);
        chk("miss2a_err", 32'(err_cnt), 32'd2);
        send_frame(1, 0, -1);
        chk("miss2b_err", 32'(err_cnt), 32'd3);
        chk("miss2b_state", 32'(state), 32'd0);
        chk("unlock_beat_fwd", 32'(obs_valid[3]), 32'd1);
        chk("after_unlock_nofwd", 32'(obs_valid[4]), 32'd0);
        chk("truncated_frame_cnt", 32'(frame_cnt), 32'd4);
        send_frame(0, 0, -1);
        send_frame(0, 0, -1);
        chk("relock_not_yet", 32'(state), 32'd1);
        send_frame(0, 0, -1);
        chk("relock_state", 32'(state), 32'd2);
        send_frame(0, 0, -1);
        chk("relock_frames", 32'(frame_cnt), 32'd5);

        // Backpressure mid-payload while forwarding.
        send_frame(0, 0, 8);
        chk("stall_tlast_16th", 32'(obs_last[15]), 32'd1);
        chk("stall_frames", 32'(frame_cnt), 32'd6);

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 5; i++) beat(hdr(i % L));
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_err", 32'(err_cnt), 32'd0);
        chk("arst_frames", 32'(frame_cnt), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        for (int f = 0; f < 4; f++) send_frame(0, 0, -1);
        chk("pre_en_frames", 32'(frame_cnt), 32'd1);
        cycle(1'b1, payload(), 1'b1, 1'b0, a);
        chk("en_state", 32'(state), 32'd0);
        chk("en_locked", 32'(locked), 32'd0);
        chk("en_frames", 32'(frame_cnt), 32'd0);

        // Header arrives one beat late while in CHECK.
        send_frame(0, 0, -1);
        chk("late_pre_state", 32'(state), 32'd1);
        send_frame(0, 1, -1);
        chk("late_miss_hunt", 32'(obs_state[4]), 32'd0);
        chk("late_reacquire", 32'(obs_state[5]), 32'd1);
        chk("late_err", 32'(err_cnt), 32'd0);
        send_frame(0, 0, -1);
        send_frame(0, 0, -1);
        chk("late_relock", 32'(state), 32'd2);

        // Randomized tail: mostly good frames with occasional corrupt headers.
        for (int f = 0; f < 8; f++) begin
            send_frame(($urandom_range(0, 3) == 0) ? 1 : 0, 0,
                       ($urandom_range(0, 2) == 0) ? int'($urandom_range(4, 14)) : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/util_sequences_sync_ctrl.md
Name: util_sequences_sync_ctrl

Overview:
Frame-alignment controller for AXI-Stream byte/word streams that carry a fixed sync header of SEQUENCES_LEN beats at the start of every FRAME_LEN-beat frame. It hunts for the header, confirms it over several frames, then holds lock.
While locked, it forwards aligned frames with tuser marking start-of-frame and tlast marking end-of-frame. It sits in front of frame-level consumers and counts header misses.

Parameters:
TDATA_WIDTH, 8, data beat width
SEQUENCES_LEN, 4, header length in beats
SEQUENCES_PACK, {8'h00,8'h00,8'h00,8'h00}, header; element ii = bits [ii*TDATA_WIDTH+:TDATA_WIDTH]; element 0 is the first transmitted beat
FRAME_LEN, 256, frame period in beats including header; must be > SEQUENCES_LEN
LOCK_CNT, 3, consecutive header hits needed to enter LOCK; must be >= 1
UNLOCK_CNT, 2, consecutive header misses in LOCK that force HUNT; must be >= 1
CNT_WIDTH, 16, width of the status counters

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
en  in  1  synchronous enable; low clears all state as if reset
s_axis_tvalid  in  1  input valid
s_axis_tdata  in  TDATA_WIDTH  input data
s_axis_tready  out  1  input ready
m_axis_tvalid  out  1  output valid
m_axis_tdata  out  TDATA_WIDTH  output data (= s_axis_tdata)
m_axis_tuser  out  1  start of frame (first header beat)
m_axis_tlast  out  1  last beat of frame
m_axis_tready  in  1  output ready
locked  out  1  state == LOCK
state  out  2  0=HUNT, 1=CHECK, 2=LOCK
err_cnt  out  CNT_WIDTH  header misses while in LOCK; saturating
frame_cnt  out  CNT_WIDTH  frames forwarded (tlast handshakes); saturating

Behaviour:
- Reset (rstn low, async) or en low (sync): state=HUNT, all counters and the history register are 0, aligned=0. All registered outputs read 0.
- Beat acceptance: acc = s_axis_tvalid & s_axis_tready.
- Ready and valid gating: s_axis_tready = m_axis_tready when fwd, else 1. In other words, data is dropped, not stalled, while not forwarding.
- Forwarding: fwd = (state==LOCK) & aligned. m_axis_tvalid = s_axis_tvalid & fwd. The data path is combinational with zero latency.
- History register: holds the last SEQUENCES_LEN-1 accepted beats and shifts on acc only.
- Header match: hit is combinational. It is true when history (oldest first) concatenated with the current s_axis_tdata equals SEQUENCES_PACK in element order. hit is only evaluated when acc.
- Beat counter: bcnt counts 0..FRAME_LEN-1 and increments on acc, wrapping to 0. The check beat is the accepted beat with bcnt == SEQUENCES_LEN-1.
- HUNT: on acc & hit, set bcnt <= SEQUENCES_LEN and hit_cnt <= 1. Go to LOCK if LOCK_CNT==1, else CHECK.
- CHECK, on the check beat:
  - hit: hit_cnt+1. If it equals LOCK_CNT, go to LOCK and set miss_cnt=0.
  - miss: go to HUNT and set hit_cnt=0.
- LOCK, on the check beat:
  - hit: miss_cnt <= 0.
  - miss: err_cnt+1 (saturating) and miss_cnt+1. If miss_cnt+1 == UNLOCK_CNT, go to HUNT and clear aligned.
  - bcnt keeps free-running through misses; there is no re-alignment while in LOCK.
- aligned flag: set on the acc beat with bcnt==FRAME_LEN-1 while in LOCK, so forwarding starts at the next bcnt==0 beat. It is cleared on any exit from LOCK. This means the partial frame in which lock is gained is never forwarded.
- tuser/tlast: m_axis_tuser = fwd & (bcnt==0). m_axis_tlast = fwd & (bcnt==FRAME_LEN-1).
- frame_cnt: increments on m_axis_tvalid & m_axis_tready & m_axis_tlast (saturating).
- Losing lock mid-frame: when HUNT is entered on a check beat, forwarding stops after that beat. The consumer sees a truncated frame with no tlast; this is intentional, and consumers use tuser to resync.
- Simultaneous events: a miss that causes unlock takes effect on the same beat the error is counted. en low overrides everything.
- Backpressure: while fwd, m_axis_tready low stalls the input; bcnt and history do not advance.

Test Plan:
- SEQUENCES_PACK={8'hDD,8'hCC,8'hBB,8'hAA}, FRAME_LEN=16, LOCK_CNT=3. Send 5 random beats, then frames AA BB CC DD + 12 payload beats → CHECK after 1st header, LOCK after 3rd. First forwarded beat is the 4th frame's AA with tuser=1; tlast is on its 16th beat; frame_cnt=1.
- From LOCK, corrupt one header (CC→00), UNLOCK_CNT=2 → err_cnt=1, state stays LOCK, the next good frame is forwarded normally.
- From LOCK, corrupt two consecutive headers → err_cnt=2, state=HUNT after the 2nd check beat, m_axis_tvalid deasserts on the next beat with no tlast emitted; re-lock needs 3 further good headers.
- In CHECK, place the header one beat late → miss, state=HUNT, err_cnt stays 0; the shifted header is then acquired as a new HUNT hit.
- In LOCK, hold m_axis_tready low for 5 cycles mid-payload → s_axis_tready low, bcnt frozen, tlast still falls on the 16th accepted beat.
- Pull rstn low mid-frame (async) and separately drop en for one cycle → state=0, locked=0, err_cnt=0, frame_cnt=0 immediately (rstn) or on the next edge (en).
